// File: rtl/mem_stage_wait_if.sv
// MEM-stage bus: EXE/MEM-side control and data in, MEM/WB-side results and
// stall out. The upstream pipeline is the master; the stage is the slave.
interface mem_stage_wait_if #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  MEM_R_EN_in;
  logic                  MEM_W_EN_in;
  logic                  WB_EN_in;
  logic [REG_ADDR_W-1:0] Dest_in;
  logic [WORD_WIDTH-1:0] Val_Rm;
  logic [WORD_WIDTH-1:0] ALU_res;

  logic                  MEM_R_EN_out;
  logic                  WB_EN_out;
  logic [REG_ADDR_W-1:0] Dest_out;
  logic [WORD_WIDTH-1:0] ALU_res_out;
  logic [WORD_WIDTH-1:0] MEM_out;
  logic                  stall;

  modport master (
    output MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Dest_in, Val_Rm, ALU_res,
    input  MEM_R_EN_out, WB_EN_out, Dest_out, ALU_res_out, MEM_out, stall
  );

  modport slave (
    input  MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Dest_in, Val_Rm, ALU_res,
    output MEM_R_EN_out, WB_EN_out, Dest_out, ALU_res_out, MEM_out, stall
  );
endinterface

// File: rtl/mem_stage_wait.sv
// MEM pipeline stage with a multi-cycle word memory. Loads and stores hold
// the pipeline via stall for WAIT_CYCLES+1 cycles; other instructions pass.
module mem_stage_wait #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_wait_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
  logic [WORD_WIDTH-1:0] mem_out;
  logic [IDX_W-1:0]      idx;
  logic                  req;

  assign req = bus.MEM_R_EN_in | bus.MEM_W_EN_in;

  // Byte address relative to the base, word-aligned, wrapped into the array.
  assign idx = IDX_W'((bus.ALU_res - WORD_WIDTH'(BASE_ADDR)) >> 2);

  assign bus.MEM_R_EN_out = bus.MEM_R_EN_in;
  assign bus.WB_EN_out    = bus.WB_EN_in;
  assign bus.Dest_out     = bus.Dest_in;
  assign bus.ALU_res_out  = bus.ALU_res;
  assign bus.MEM_out      = mem_out;

  // Stall rises in the same cycle the request appears so the upstream
  // registers freeze immediately; it is forced low while in reset.
  assign bus.stall = ~rst & ((state == IDLE & req) | (state == BUSY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_out <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= CNT_W'(WAIT_CYCLES - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Nonblocking read and write on the same edge: read-before-write.
            if (bus.MEM_R_EN_in) mem_out  <= mem[idx];
            if (bus.MEM_W_EN_in) mem[idx] <= bus.Val_Rm;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait: three instances with WAIT_CYCLES 2, 1, 5.
module tb_mem_stage_wait;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_wait_if #(.WORD_WIDTH(32), .REG_ADDR_W(4)) b0 ();
  mem_stage_wait_if #(.WORD_WIDTH(32), .REG_ADDR_W(4)) b1 ();
  mem_stage_wait_if #(.WORD_WIDTH(32), .REG_ADDR_W(4)) b2 ();

  mem_stage_wait #(.WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst0), .bus(b0));
  mem_stage_wait #(.WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_stage_wait #(.WAIT_CYCLES(5)) u_w5 (.clk(clk), .rst(rst2), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic r, input logic w, input logic wb,
                        input logic [3:0] d, input logic [31:0] addr, input logic [31:0] data);
    case (sel)
      0: begin
        b0.MEM_R_EN_in = r; b0.MEM_W_EN_in = w; b0.WB_EN_in = wb;
        b0.Dest_in = d; b0.ALU_res = addr; b0.Val_Rm = data;
      end
      1: begin
        b1.MEM_R_EN_in = r; b1.MEM_W_EN_in = w; b1.WB_EN_in = wb;
        b1.Dest_in = d; b1.ALU_res = addr; b1.Val_Rm = data;
      end
      default: begin
        b2.MEM_R_EN_in = r; b2.MEM_W_EN_in = w; b2.WB_EN_in = wb;
        b2.Dest_in = d; b2.ALU_res = addr; b2.Val_Rm = data;
      end
    endcase
  endtask

  task automatic set_rst(input int sel, input logic v);
    case (sel)
      0:       rst0 = v;
      1:       rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  function automatic logic stall_of(input int sel);
    case (sel)
      0:       return b0.stall;
      1:       return b1.stall;
      default: return b2.stall;
    endcase
  endfunction

  function automatic logic [31:0] mem_of(input int sel);
    case (sel)
      0:       return b0.MEM_out;
      1:       return b1.MEM_out;
      default: return b2.MEM_out;
    endcase
  endfunction

  // One access: counts stall-high cycles and returns MEM_out in the DONE cycle.
  // rst_at>0 asserts reset in the rst_at-th stall-high cycle instead.
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] data, input int rst_at,
                        output int width, output logic [31:0] rdata,
                        output int t_start, output int t_done);
    logic fin;
    @(negedge clk);
    set_in(sel, r, w, 1'b0, 4'd0, addr, data);
    #1;
    width = 0; fin = 1'b0; t_start = -1; t_done = -1;
    for (int n = 0; n < 30 && !fin; n++) begin
      if (stall_of(sel)) begin
        if (width == 0) t_start = cyc;
        width++;
        if (width == rst_at) begin
          set_rst(sel, 1'b1);
          #1 chk("stall_in_rst", 32'(stall_of(sel)), 32'd0);
          fin = 1'b1;
        end
      end else if (width > 0) begin
        fin = 1'b1;
        t_done = cyc;
      end
      if (!fin) begin
        @(negedge clk);
        #1;
      end
    end
    if (!fin) chk("timeout", 32'(fin), 32'd1);
    rdata = mem_of(sel);
    if (rst_at > 0 && width == rst_at) begin
      @(negedge clk);
      set_rst(sel, 1'b0);
    end
    set_in(sel, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  int          wd, ts, td, ts2, td2;
  logic [31:0] rd;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    chk("rst_mem_out", b0.MEM_out, 32'd0);
    chk("rst_stall", 32'(b0.stall), 32'd0);

    // 1: load from base after reset
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 0, wd, rd, ts, td);
    chk("t1_width", 32'(wd), 32'd3);
    chk("t1_data", rd, 32'd0);

    // 2: store then back-to-back load, one-cycle gap
    access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0, wd, rd, ts, td);
    chk("t2_st_width", 32'(wd), 32'd3);
    chk("t2_st_hold", rd, 32'd0);
    access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 0, wd, rd, ts2, td2);
    chk("t2_ld_width", 32'(wd), 32'd3);
    chk("t2_gap", 32'(ts2 - td), 32'd1);
    chk("t2_data", rd, 32'hDEADBEEF);

    // 3: non-memory instruction passes through without stalling
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h55, 32'h1234);
    #1;
    chk("t3_alu", b0.ALU_res_out, 32'h55);
    chk("t3_wb", 32'(b0.WB_EN_out), 32'd1);
    chk("t3_dest", 32'(b0.Dest_out), 32'd5);
    chk("t3_mren", 32'(b0.MEM_R_EN_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall", 32'(b0.stall), 32'd0);
      @(negedge clk);
      #1;
    end
    chk("t3_mem_hold", b0.MEM_out, 32'hDEADBEEF);
    set_in(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    // 4: read-before-write when R and W are both set
    access(0, 1'b0, 1'b1, 32'd1024, 32'h11, 0, wd, rd, ts, td);
    access(0, 1'b1, 1'b1, 32'd1024, 32'h22, 0, wd, rd, ts, td);
    chk("t4_rbw", rd, 32'h11);
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 0, wd, rd, ts, td);
    chk("t4_after", rd, 32'h22);

    // 5: address wrap and ignored low bits
    access(0, 1'b0, 1'b1, 32'd1280, 32'h77, 0, wd, rd, ts, td);
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 0, wd, rd, ts, td);
    chk("t5_wrap", rd, 32'h77);
    access(0, 1'b1, 1'b0, 32'd1027, 32'd0, 0, wd, rd, ts, td);
    chk("t5_lowbits", rd, 32'h77);

    // 6: reset during the access edge cycle cancels the store
    access(0, 1'b0, 1'b1, 32'd1032, 32'h99, 3, wd, rd, ts, td);
    chk("t6_rst_width", 32'(wd), 32'd3);
    access(0, 1'b1, 1'b0, 32'd1032, 32'd0, 0, wd, rd, ts, td);
    chk("t6_cancel", rd, 32'd0);
    access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 0, wd, rd, ts, td);
    chk("t6_mem_clear", rd, 32'd0);

    // WAIT_CYCLES=1 instance
    access(1, 1'b0, 1'b1, 32'd1036, 32'h5A, 0, wd, rd, ts, td);
    chk("w1_width", 32'(wd), 32'd2);
    access(1, 1'b1, 1'b0, 32'd1036, 32'd0, 0, wd, rd, ts, td);
    chk("w1_data", rd, 32'h5A);
    access(1, 1'b0, 1'b1, 32'd1032, 32'h99, 2, wd, rd, ts, td);
    access(1, 1'b1, 1'b0, 32'd1032, 32'd0, 0, wd, rd, ts, td);
    chk("w1_cancel", rd, 32'd0);

    // WAIT_CYCLES=5 instance
    access(2, 1'b0, 1'b1, 32'd1036, 32'hA5, 0, wd, rd, ts, td);
    chk("w5_width", 32'(wd), 32'd6);
    access(2, 1'b1, 1'b0, 32'd1036, 32'd0, 0, wd, rd, ts, td);
    chk("w5_data", rd, 32'hA5);
    access(2, 1'b0, 1'b1, 32'd1032, 32'h99, 6, wd, rd, ts, td);
    access(2, 1'b1, 1'b0, 32'd1032, 32'd0, 0, wd, rd, ts, td);
    chk("w5_cancel", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
